// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator / decoder pair:
// note codes, FSM states, frequency table and nominal half-periods.
`timescale 1ns/1ps
package tone_pkg;

    localparam int CLK_MHZ_DEF = 25;
    localparam int NUM_NOTES   = 7;
    localparam int CNT_W       = 20;

    localparam logic [2:0] NOTE_A = 3'd0;
    localparam logic [2:0] NOTE_B = 3'd1;
    localparam logic [2:0] NOTE_C = 3'd2;
    localparam logic [2:0] NOTE_D = 3'd3;
    localparam logic [2:0] NOTE_E = 3'd4;
    localparam logic [2:0] NOTE_F = 3'd5;
    localparam logic [2:0] NOTE_G = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    function automatic int freq_hz(input int k);
        case (k)
            0:       return 220;
            1:       return 247;
            2:       return 261;
            3:       return 294;
            4:       return 330;
            5:       return 349;
            default: return 392;
        endcase
    endfunction

    // Half-period in clk cycles, rounded down then plus one so the
    // generator's toggle interval and the decoder's target agree.
    function automatic int half_period(input int clk_mhz, input int k);
        return ((clk_mhz * 1000000) / freq_hz(k)) / 2 + 1;
    endfunction

endpackage

// File: rtl/tone_decoder_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone input followed
// by a detector that flags both rising and falling transitions.
`timescale 1ns/1ps
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic wave_in,
    output logic toggle
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= wave_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign toggle = sync2 ^ prev;

endmodule

// File: rtl/tone_decoder.sv
// Measures half-periods of a square-wave tone, classifies them
// against the note table and locks after two agreeing intervals.
`timescale 1ns/1ps
import tone_pkg::*;

module tone_decoder #(
    parameter int CLK_MHZ = CLK_MHZ_DEF,
    parameter int TOL     = 512,
    parameter int TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wave_in,
    output logic [2:0] note,
    output logic       valid,
    output logic       new_note
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             toggle;
    logic [CNT_W-1:0] interval;
    logic             hit;
    logic [2:0]       hit_k;
    logic             timed_out;
    state_t           state;
    logic [2:0]       cand;

    edge_sync u_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .wave_in (wave_in),
        .toggle  (toggle)
    );

    // Cycles since the last edge; reads as t1-t0 on the edge cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            interval <= '0;
        end else if (toggle) begin
            interval <= CNT_W'(1);
        end else if (interval != CNT_MAX) begin
            interval <= interval + CNT_W'(1);
        end
    end

    // Window match of the current interval against each note.
    always_comb begin
        int iv;
        int nom;
        hit   = 1'b0;
        hit_k = 3'd0;
        iv    = int'({12'd0, interval});
        for (int k = NUM_NOTES - 1; k >= 0; k--) begin
            nom = half_period(CLK_MHZ, k);
            if (iv >= nom - TOL && iv <= nom + TOL) begin
                hit   = 1'b1;
                hit_k = 3'(k);
            end
        end
    end

    assign timed_out = int'({12'd0, interval}) >= TIMEOUT;

    // Lock FSM with registered outputs; an edge beats a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cand     <= 3'd0;
            note     <= 3'd0;
            valid    <= 1'b0;
            new_note <= 1'b0;
        end else begin
            new_note <= 1'b0;
            if (toggle) begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        if (hit) begin
                            state <= ST_CONFIRM;
                            cand  <= hit_k;
                        end
                    end
                    ST_CONFIRM: begin
                        if (!hit) begin
                            state <= ST_MEASURE;
                        end else if (hit_k == cand) begin
                            state    <= ST_LOCKED;
                            note     <= cand;
                            valid    <= 1'b1;
                            new_note <= 1'b1;
                        end else begin
                            cand <= hit_k;
                        end
                    end
                    ST_LOCKED: begin
                        if (!hit) begin
                            state <= ST_MEASURE;
                            valid <= 1'b0;
                        end else if (hit_k != note) begin
                            state <= ST_CONFIRM;
                            cand  <= hit_k;
                            valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE && timed_out) begin
                state <= ST_IDLE;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter CLK_MHZ, default 25, system clock frequency in MHz used for nominal half-period table.
REQ-002 Parameter TOL, default 512, accepted half-period deviation in clk cycles (inclusive).
REQ-003 Parameter TIMEOUT, default 65536, clk cycles without an edge before signal is declared lost.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wave_in  input  1  asynchronous square-wave tone from the note generator.
REQ-007 note  output  3  decoded note code: A=0, B=1, C=2, D=3, E=4, F=5, G=6.
REQ-008 valid  output  1  high while a note is locked.
REQ-009 new_note  output  1  one-cycle pulse when a note becomes locked or the locked note changes.

Function
REQ-010 wave_in SHALL pass a 2-flop synchronizer, then an edge detector flagging both rising and falling transitions.
REQ-011 Interval SHALL be t1-t0 for consecutive detected edges at clk cycles t0, t1; the interval counter saturates at 2^20-1.
REQ-012 Nominal half-period N(k) = floor(CLK_MHZ*10^6 / f(k) / 2) + 1, f = 220,247,261,294,330,349,392 Hz (25 MHz: 56819,50608,47893,42518,37879,35817,31888).
REQ-013 An interval SHALL match note k iff |interval - N(k)| <= TOL; with default TOL at most one k can match; otherwise no match.
REQ-014 States: IDLE, MEASURE, CONFIRM, LOCKED; candidate register cand[2:0].
REQ-015 IDLE: any edge -> MEASURE (restart interval).
REQ-016 MEASURE: edge with match k -> CONFIRM, cand=k; edge with no match -> stay MEASURE.
REQ-017 CONFIRM: edge matching cand -> LOCKED, note=cand, valid=1, new_note=1; match k!=cand -> CONFIRM, cand=k; no match -> MEASURE.
REQ-018 LOCKED: edge matching note -> stay, no pulse; match k!=note -> CONFIRM, cand=k, valid=0; no match -> MEASURE, valid=0.
REQ-019 new_note SHALL pulse on every entry to LOCKED, including re-lock to the same note.
REQ-020 Any non-IDLE state: interval reaching TIMEOUT without an edge -> IDLE, valid=0, on that same cycle.
REQ-021 note SHALL hold its last locked value when valid deasserts; undefined-free (never X).
REQ-022 Latency: note/valid/new_note update exactly 3 clk rising edges after the edge-completing wave_in transition is first sampled.
REQ-023 Edge and timeout on the same cycle: edge wins.

Reset
REQ-024 reset SHALL force state=IDLE, note=0, valid=0, new_note=0, cand=0, interval=0, synchronizer and edge-detect flops=0 on the next clk edge.
REQ-025 reset mid-lock SHALL discard all measurement; first post-reset edge is treated as an IDLE edge.

Structure
REQ-026 Shared package tone_pkg SHALL hold note codes, CLK_MHZ default, frequency table, and the N(k) computation shared with the generator.
REQ-027 One sub-module edge_sync (2-flop synchronizer + both-edge detector) SHALL be instantiated; classifier and FSM live in tone_decoder.

Verification
REQ-028 Reset, then 220 Hz wave (half-period 56819 cycles) -> after third edge valid=1, note=0, one new_note pulse, 3-cycle latency.
REQ-029 Locked at A, switch to 392 Hz -> valid=0 on first G interval, note holds 0; second G interval -> note=6, valid=1, new_note pulse.
REQ-030 Half-period 53700 (between A and B) continuously -> valid never asserts, state alternates within MEASURE.
REQ-031 Intervals N(2)+512 accepted and N(2)+513 rejected; same for -512/-513.
REQ-032 Stop wave while locked -> valid=0 exactly 65536 cycles after last edge, note holds, next edge enters MEASURE.
REQ-033 Assert reset for one cycle while locked at E -> next cycle valid=0, note=0, new_note=0; relock needs three fresh edges.
